// File: rtl/ap_pkg.sv
// Shared associative-processor definitions: op encodings, sequencer states and
// the per-op pass tables used by the decoder, sequencer and array model.
package ap_pkg;

  typedef enum logic [1:0] {
    AP_OP_ADD  = 2'd0,
    AP_OP_NOT  = 2'd1,
    AP_OP_CLRC = 2'd2,
    AP_OP_RSVD = 2'd3
  } ap_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CMP,
    ST_WR,
    ST_DONE
  } ap_state_e;

  localparam logic [2:0] AP_NPASS_ADD = 3'd4;
  localparam logic [2:0] AP_NPASS_NOT = 3'd1;

  // Element [0] is pass 1. The order is such that no pass matches an earlier result.
  localparam logic [3:0][2:0] AP_ADD_KEY  = {3'b110, 3'b100, 3'b001, 3'b011};
  localparam logic [3:0][1:0] AP_ADD_WR   = {2'b10, 2'b01, 2'b01, 2'b10};
  localparam logic [2:0]      AP_ADD_MASK = 3'b111;

  // NOT matches every row; the cell writes ~B on pass 1, so wr_data is a don't-care zero.
  localparam logic [2:0] AP_NOT_KEY  = 3'b000;
  localparam logic [2:0] AP_NOT_MASK = 3'b000;
  localparam logic [1:0] AP_NOT_WR   = 2'b00;

  localparam logic [2:0] AP_INIT_MASK = 3'b100;

  function automatic logic [2:0] ap_npass(input ap_op_e op);
    case (op)
      AP_OP_ADD: return AP_NPASS_ADD;
      AP_OP_NOT: return AP_NPASS_NOT;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ap_pass_rom.sv
// Combinational pass-table lookup: (op, pass number) -> compare key/mask and write data.
module ap_pass_rom
  import ap_pkg::*;
(
  input  ap_op_e      op,
  input  logic [2:0]  pass_cnt,
  output logic [2:0]  key,
  output logic [2:0]  mask,
  output logic [1:0]  wr_data
);

  logic [1:0] idx;
  assign idx = pass_cnt[1:0] - 2'd1;

  always_comb begin
    key     = '0;
    mask    = '0;
    wr_data = '0;
    case (op)
      AP_OP_ADD: begin
        if (pass_cnt >= 3'd1 && pass_cnt <= 3'd4) begin
          key     = AP_ADD_KEY[idx];
          mask    = AP_ADD_MASK;
          wr_data = AP_ADD_WR[idx];
        end
      end
      AP_OP_NOT: begin
        key     = AP_NOT_KEY;
        mask    = AP_NOT_MASK;
        wr_data = AP_NOT_WR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ap_pass_sequencer.sv
// Bit-serial pass sequencer: for each bit slice issues compare/write cycle pairs
// per pass of the latched op, driving the associative cell arrays.
module ap_pass_sequencer
  import ap_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int BIT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_In,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             hold,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [BIT_W-1:0] bit_idx,
  output logic             cmp_en,
  output logic [2:0]       key,
  output logic [2:0]       mask,
  output logic             wr_en,
  output logic [1:0]       wr_data,
  output logic [2:0]       pass
);

  ap_state_e        state, state_d;
  ap_op_e           op_q, op_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [2:0]       pass_q, pass_d;
  logic [2:0]       rom_key, rom_mask;
  logic [1:0]       rom_wr;

  ap_pass_rom u_rom (
    .op      (op_q),
    .pass_cnt(pass_q),
    .key     (rom_key),
    .mask    (rom_mask),
    .wr_data (rom_wr)
  );

  // Hold freezes every register outside IDLE; outputs are decoded from them only.
  always_ff @(posedge clk or posedge rst_In) begin
    if (rst_In) begin
      state  <= ST_IDLE;
      op_q   <= AP_OP_ADD;
      bit_q  <= '0;
      pass_q <= '0;
    end else if (!(hold && state != ST_IDLE)) begin
      state  <= state_d;
      op_q   <= op_d;
      bit_q  <= bit_d;
      pass_q <= pass_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    done    = 1'b0;
    cmp_en  = 1'b0;
    key     = '0;
    mask    = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    pass    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_d   = ap_op_e'(op);
          bit_d  = '0;
          pass_d = 3'd1;
          case (ap_op_e'(op))
            AP_OP_ADD, AP_OP_CLRC: state_d = ST_INIT;
            AP_OP_NOT:             state_d = ST_CMP;
            default:               state_d = ST_DONE;
          endcase
        end
      end
      ST_INIT: begin
        wr_en   = 1'b1;
        mask    = AP_INIT_MASK;
        state_d = (op_q == AP_OP_CLRC) ? ST_DONE : ST_CMP;
      end
      ST_CMP: begin
        cmp_en  = 1'b1;
        key     = rom_key;
        mask    = rom_mask;
        state_d = ST_WR;
      end
      ST_WR: begin
        wr_en   = 1'b1;
        pass    = pass_q;
        wr_data = rom_wr;
        if (pass_q < ap_npass(op_q)) begin
          pass_d  = pass_q + 3'd1;
          state_d = ST_CMP;
        end else if (bit_q < BIT_W'(WORD_WIDTH - 1)) begin
          bit_d   = bit_q + 1'b1;
          pass_d  = 3'd1;
          state_d = ST_CMP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready   = (state == ST_IDLE);
  assign busy    = ~ready;
  assign bit_idx = bit_q;

endmodule

// File: tb/tb_ap_pass_sequencer.sv
// Bench for ap_pass_sequencer: per-cycle output trace model plus a bit-serial
// associative array driven by the DUT and checked against plain arithmetic.
module tb_ap_pass_sequencer;

  localparam int WW = 16;
  localparam int NR = 6;

  logic       clk = 1'b0;
  logic       rst_In = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic       hold = 1'b0;
  logic       ready, busy, done, cmp_en, wr_en;
  logic [3:0] bit_idx;
  logic [2:0] key, mask, pass;
  logic [1:0] wr_data;

  always #5 clk = ~clk;

  ap_pass_sequencer #(.WORD_WIDTH(WW), .BIT_W(4)) dut (
    .clk(clk), .rst_In(rst_In), .start(start), .op(op), .hold(hold),
    .ready(ready), .busy(busy), .done(done), .bit_idx(bit_idx),
    .cmp_en(cmp_en), .key(key), .mask(mask), .wr_en(wr_en),
    .wr_data(wr_data), .pass(pass)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] bit_idx;
    logic       cmp_en;
    logic [2:0] key;
    logic [2:0] mask;
    logic       wr_en;
    logic [1:0] wr_data;
    logic [2:0] pass;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

  function automatic vec_t idle_v(input logic [3:0] b);
    vec_t v;
    v = '0;
    v.ready = 1'b1;
    v.bit_idx = b;
    return v;
  endfunction

  // Expected per-cycle output trace of one operation, from acceptance onward.
  task automatic build(input logic [1:0] o, output vec_t s[$]);
    vec_t v;
    int add_key[4] = '{3, 1, 4, 6};
    int add_wr[4]  = '{2, 1, 1, 2};
    int np;
    s.delete();
    if (o == 2'd0 || o == 2'd2) begin
      v = '0; v.busy = 1'b1; v.wr_en = 1'b1; v.mask = 3'b100;
      s.push_back(v);
    end
    if (o == 2'd0 || o == 2'd1) begin
      np = (o == 2'd0) ? 4 : 1;
      for (int b = 0; b < WW; b++) begin
        for (int p = 1; p <= np; p++) begin
          v = '0; v.busy = 1'b1; v.bit_idx = 4'(b); v.cmp_en = 1'b1;
          v.key  = (o == 2'd0) ? 3'(add_key[p-1]) : 3'b000;
          v.mask = (o == 2'd0) ? 3'b111 : 3'b000;
          s.push_back(v);
          v = '0; v.busy = 1'b1; v.bit_idx = 4'(b); v.wr_en = 1'b1; v.pass = 3'(p);
          v.wr_data = (o == 2'd0) ? 2'(add_wr[p-1]) : 2'b00;
          s.push_back(v);
        end
      end
    end
    v = '0; v.busy = 1'b1; v.done = 1'b1;
    v.bit_idx = (o <= 2'd1) ? 4'(WW - 1) : 4'd0;
    s.push_back(v);
  endtask

  vec_t mq[$];
  vec_t cur = idle_v(4'd0);

  always @(posedge clk or posedge rst_In) begin
    if (rst_In) begin
      mq.delete();
      cur = idle_v(4'd0);
    end else if (cur.ready) begin
      if (start === 1'b1) begin
        build(op, mq);
        cur = mq.pop_front();
      end
    end else if (!hold) begin
      if (mq.size() > 0) cur = mq.pop_front();
      else cur = idle_v(cur.bit_idx);
    end
  end

  always @(posedge clk) cyc++;

  // Associative array: rows of A/B words plus a carry bit, updated by DUT commands.
  logic [15:0] A[NR], B[NR];
  logic        C[NR], tag[NR];
  logic [1:0]  arr_op = 2'd0;

  always @(negedge clk) begin
    vec_t dv;
    dv = {ready, busy, done, bit_idx, cmp_en, key, mask, wr_en, wr_data, pass};
    nvec++;
    if (dv !== cur) begin
      nmis++;
      $display("FAIL outputs t=%0t got=%h expected=%h", $time, dv, cur);
    end
    nvec++;
    if (cmp_en === 1'b1 && wr_en === 1'b1) begin
      nmis++;
      $display("FAIL cmp_wr_exclusive t=%0t got=11 expected=not both", $time);
    end
    if (!rst_In && !hold) begin
      if (cmp_en) begin
        for (int r = 0; r < NR; r++)
          tag[r] = ((({C[r], B[r][bit_idx], A[r][bit_idx]} ^ key) & mask) == 3'b000);
      end
      if (wr_en) begin
        for (int r = 0; r < NR; r++) begin
          if (pass == 3'd0) C[r] = 1'b0;
          else if (tag[r]) begin
            if (arr_op == 2'd1) B[r][bit_idx] = ~B[r][bit_idx];
            else {C[r], B[r][bit_idx]} = wr_data;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic init_rows();
    for (int r = 0; r < NR; r++) begin
      A[r] = 16'($urandom);
      B[r] = 16'($urandom);
      C[r] = 1'($urandom);
      tag[r] = 1'b0;
    end
  endtask

  // mode: 0 plain, 1 stray starts, 2 random holds and starts, 3 hold 5 at bit 7 pass 3
  task automatic run_op(input logic [1:0] o, input int mode, input int exp_lat);
    logic [15:0] eB[NR];
    logic        eC[NR];
    int t0, t1, hcnt;
    bit seen, fin, h7;
    for (int r = 0; r < NR; r++) begin
      case (o)
        2'd0:    {eC[r], eB[r]} = {1'b0, A[r]} + {1'b0, B[r]};
        2'd1:    begin eB[r] = ~B[r]; eC[r] = C[r]; end
        2'd2:    begin eB[r] = B[r];  eC[r] = 1'b0; end
        default: begin eB[r] = B[r];  eC[r] = C[r]; end
      endcase
    end
    arr_op = o;
    @(posedge clk); #1;
    start = 1'b1; op = o;
    hold = (mode == 2) ? 1'($urandom % 2) : 1'b0;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    seen = 0; fin = 0; h7 = 0; hcnt = 0; t1 = 0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      if (done && !seen) begin seen = 1; t1 = cyc; end
      if (ready) begin
        fin = 1; start = 1'b0; hold = 1'b0;
      end else begin
        @(posedge clk); #1;
        case (mode)
          1: begin start = ($urandom % 3 == 0); op = 2'($urandom); end
          2: begin start = ($urandom % 3 == 0); op = 2'($urandom); hold = ($urandom % 4 == 0); end
          3: begin
            if (hcnt > 0) begin
              hcnt--;
              if (hcnt == 0) hold = 1'b0;
            end else if (!h7 && cur.wr_en && cur.bit_idx == 4'd7 && cur.pass == 3'd3) begin
              hold = 1'b1; hcnt = 5; h7 = 1;
            end
          end
          default: ;
        endcase
      end
    end
    chk("op_finished", 32'(fin), 32'd1);
    chk("done_seen", 32'(seen), 32'd1);
    if (exp_lat >= 0) chk("latency", 32'(t1 - t0), 32'(exp_lat));
    if (mode == 3) chk("hold_injected", 32'(h7), 32'd1);
    for (int r = 0; r < NR; r++) begin
      chk("row_B", 32'(B[r]), 32'(eB[r]));
      chk("row_C", 32'(C[r]), 32'(eC[r]));
    end
  endtask

  initial begin
    vec_t tmp[$];
    init_rows();
    repeat (3) @(posedge clk);
    #1 rst_In = 1'b0;
    chk("reset_outputs", 32'({ready, busy, done, bit_idx, cmp_en, key, mask, wr_en, wr_data, pass}),
        32'h80000);

    build(2'd0, tmp);
    chk("model_add_len", 32'(tmp.size()), 32'd130);
    chk("model_add_init", 32'({tmp[0].wr_en, tmp[0].mask, tmp[0].pass}), 32'b1_100_000);
    chk("model_add_p1", 32'({tmp[1].cmp_en, tmp[1].key, tmp[1].mask}), 32'b1_011_111);
    chk("model_add_w1", 32'({tmp[2].wr_data, tmp[2].pass}), 32'b10_001);
    chk("model_add_p4", 32'({tmp[7].key, tmp[8].wr_data, tmp[8].pass}), 32'b110_10_100);
    chk("model_add_b1", 32'({tmp[9].bit_idx, tmp[9].key}), 32'b0001_011);
    build(2'd1, tmp);
    chk("model_not_len", 32'(tmp.size()), 32'd33);
    build(2'd3, tmp);
    chk("model_nop", 32'({tmp.size(), tmp[0].done}), {32'd1, 1'b1});

    init_rows();
    A[0] = 16'h00FF; B[0] = 16'h0001;
    run_op(2'd0, 0, 129);
    chk("add_result", 32'(B[0]), 32'h0100);

    for (int r = 0; r < NR; r++) begin A[r] = 16'hFFFF; B[r] = 16'h0001; end
    run_op(2'd0, 0, 129);
    for (int r = 0; r < NR; r++) chk("add_carry", 32'({C[r], B[r]}), 32'h10000);

    init_rows();
    B[0] = 16'hA5A5;
    run_op(2'd1, 1, 32);
    chk("not_result", 32'(B[0]), 32'h5A5A);

    init_rows();
    run_op(2'd0, 3, 134);

    init_rows();
    run_op(2'd2, 0, 1);
    run_op(2'd3, 0, 0);

    @(posedge clk); #1 start = 1'b1; op = 2'd0; arr_op = 2'd0;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_In = 1'b1;
    #1 chk("async_reset", 32'({ready, busy, done, bit_idx, cmp_en, key, mask, wr_en, wr_data, pass}),
           32'h80000);
    #4 rst_In = 1'b0;

    for (int k = 0; k < 10; k++) begin
      init_rows();
      run_op(2'($urandom), 2, -1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
